// File: rtl/bit_serializer_piso.sv
// bit_serializer_piso: parallel-in/serial-out shifter with a one-word holding buffer
// so that back-to-back words stream with no gap between them.
module bit_serializer_piso #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             x_out,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] hbuf;
    logic             hbuf_v;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             consume;
    logic             last;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    assign in_ready = !hbuf_v;
    assign accept   = in_valid & !hbuf_v;
    assign consume  = (state == SHIFT) & bit_en;
    assign last     = consume & (cnt == LAST);
    assign load     = hbuf_v & ((state == IDLE) | last);
    assign shifted  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    assign x_valid  = (state == SHIFT);
    assign x_out    = x_valid & (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
    assign busy     = (state == SHIFT) | hbuf_v;

    // accept and load are mutually exclusive: accept needs hbuf_v=0, load needs hbuf_v=1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hbuf      <= '0;
            hbuf_v    <= 1'b0;
            sreg      <= '0;
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= last;
            if (accept) begin
                hbuf   <= in_data;
                hbuf_v <= 1'b1;
            end
            if (load) begin
                sreg   <= hbuf;
                cnt    <= '0;
                hbuf_v <= 1'b0;
                state  <= SHIFT;
            end else if (last) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (consume) begin
                sreg <= shifted;
                cnt  <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_bit_serializer_piso.sv
// tb_bit_serializer_piso: directed and random checks of both bit orders against a
// word-queue reference model of the emitted serial stream.
module tb_bit_serializer_piso;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       bit_en = 1'b0;
    logic [1:0] in_ready, x_out, x_valid, word_done, busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] wq[$];
    int         idx = 0;
    logic       pend_done = 1'b0;

    always #5 clk = ~clk;

    bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready[0]), .bit_en(bit_en), .x_out(x_out[0]),
        .x_valid(x_valid[0]), .word_done(word_done[0]), .busy(busy[0])
    );

    bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready[1]), .bit_en(bit_en), .x_out(x_out[1]),
        .x_valid(x_valid[1]), .word_done(word_done[1]), .busy(busy[1])
    );

    // Reference: the serial stream is the accepted words in order, each bit consumed
    // when x_valid & bit_en; busy means some accepted word still has unconsumed bits.
    always @(negedge clk) begin
        logic [7:0] w;
        logic       eb;
        if (!reset) begin
            wq.delete();
            idx = 0;
            pend_done = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (busy[i] !== (wq.size() > 0)) begin
                    miscompares++;
                    $display("FAIL mon_busy[%0d]: got %b want %b", i, busy[i], wq.size() > 0);
                end
                vectors++;
                if (word_done[i] !== pend_done) begin
                    miscompares++;
                    $display("FAIL mon_word_done[%0d]: got %b want %b", i, word_done[i], pend_done);
                end
                if (x_valid[i] === 1'b1) begin
                    vectors++;
                    if (wq.size() == 0) begin
                        miscompares++;
                        $display("FAIL mon_spurious[%0d]: x_valid=1 with no pending bits", i);
                    end else begin
                        w = wq[0];
                        eb = (i == 0) ? w[7-idx] : w[idx];
                        if (x_out[i] !== eb) begin
                            miscompares++;
                            $display("FAIL mon_bit[%0d]: got %b want %b (word %h bit %0d)", i, x_out[i], eb, w, idx);
                        end
                    end
                end else begin
                    vectors++;
                    if (x_out[i] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL mon_idle_x[%0d]: got %b want 0", i, x_out[i]);
                    end
                end
            end
            pend_done = 1'b0;
            if (x_valid[0] === 1'b1 && bit_en && wq.size() > 0) begin
                idx++;
                if (idx == 8) begin
                    void'(wq.pop_front());
                    idx = 0;
                    pend_done = 1'b1;
                end
            end
            if (in_valid && in_ready[0] === 1'b1) wq.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 6; c++) begin
            tick();
            in_valid = 1'($urandom);
            bit_en   = 1'($urandom);
            in_data  = 8'($urandom);
            #1;
            vectors++;
            if (in_ready !== 2'b11 || x_valid !== 2'b00 || x_out !== 2'b00 ||
                busy !== 2'b00 || word_done !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_outputs: ready=%b valid=%b x=%b busy=%b done=%b want 11 00 00 00 00",
                         in_ready, x_valid, x_out, busy, word_done);
            end
        end
        tick();
        in_valid = 1'b0;
        bit_en = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] w = 8'hD0;
        int wd = 0;
        in_valid = 1'b1; in_data = w; bit_en = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (x_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_latency: x_valid got %b want 0", x_valid[0]);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (x_valid[0] !== 1'b1 || x_out[0] !== w[7-k]) begin
                miscompares++;
                $display("FAIL single_bit%0d: valid=%b x=%b want 1 %b", k, x_valid[0], x_out[0], w[7-k]);
            end
            wd += int'(word_done[0]);
            tick();
        end
        wd += int'(word_done[0]);
        vectors++;
        if (word_done[0] !== 1'b1 || x_valid[0] !== 1'b0 || wd != 1) begin
            miscompares++;
            $display("FAIL single_end: done=%b valid=%b pulses=%0d want 1 0 1", word_done[0], x_valid[0], wd);
        end
        tick();
        vectors++;
        if (word_done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_once: got %b want 0", word_done[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s = 16'hD06C;
        int wd = 0;
        in_valid = 1'b1; in_data = 8'hD0; bit_en = 1'b1;
        tick();
        in_data = 8'h6C;
        vectors++;
        if (in_ready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready_held: got %b want 0", in_ready[0]);
        end
        tick();
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (x_valid[0] !== 1'b1 || x_out[0] !== s[15-k]) begin
                miscompares++;
                $display("FAIL b2b_bit%0d: valid=%b x=%b want 1 %b", k, x_valid[0], x_out[0], s[15-k]);
            end
            if (k < 2) begin
                vectors++;
                if (in_ready[0] !== (k == 0)) begin
                    miscompares++;
                    $display("FAIL b2b_ready%0d: got %b want %b", k, in_ready[0], k == 0);
                end
            end
            if (k == 1) in_valid = 1'b0;
            wd += int'(word_done[0]);
            tick();
        end
        wd += int'(word_done[0]);
        vectors++;
        if (wd != 2 || x_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: pulses=%0d valid=%b want 2 0", wd, x_valid[0]);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [7:0] w = 8'hA5;
        logic [3:0] pat = 4'b1001;
        int k = 0;
        int c = 0;
        in_valid = 1'b1; in_data = w; bit_en = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        while (k < 8 && c < 64) begin
            bit_en = pat[c%4];
            vectors++;
            if (x_valid[0] !== 1'b1 || x_out[0] !== w[7-k]) begin
                miscompares++;
                $display("FAIL stall_c%0d: valid=%b x=%b want 1 %b", c, x_valid[0], x_out[0], w[7-k]);
            end
            tick();
            if (pat[c%4]) k++;
            c++;
        end
        vectors++;
        if (k != 8 || word_done[0] !== 1'b1 || x_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_end: bits=%0d done=%b valid=%b want 8 1 0", k, word_done[0], x_valid[0]);
        end
        bit_en = 1'b1;
        tick();
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq = 8'b11010000;
        in_valid = 1'b1; in_data = 8'h0B; bit_en = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (x_valid[1] !== 1'b1 || x_out[1] !== seq[7-k]) begin
                miscompares++;
                $display("FAIL lsb_bit%0d: valid=%b x=%b want 1 %b", k, x_valid[1], x_out[1], seq[7-k]);
            end
            tick();
        end
        vectors++;
        if (word_done[1] !== 1'b1 || x_valid[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_end: done=%b valid=%b want 1 0", word_done[1], x_valid[1]);
        end
        tick();
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w = 8'h80;
        in_valid = 1'b1; in_data = 8'hFF; bit_en = 1'b1;
        tick();
        in_data = 8'h00;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (x_valid !== 2'b00 || in_ready !== 2'b11 || busy !== 2'b00 || x_out !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_outputs: valid=%b ready=%b busy=%b x=%b want 00 11 00 00",
                     x_valid, in_ready, busy, x_out);
        end
        tick();
        reset = 1'b1;
        tick();
        in_valid = 1'b1; in_data = w;
        tick();
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (x_valid[0] !== 1'b1 || x_out[0] !== w[7-k]) begin
                miscompares++;
                $display("FAIL midreset_bit%0d: valid=%b x=%b want 1 %b", k, x_valid[0], x_out[0], w[7-k]);
            end
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (x_valid !== 2'b00 || busy !== 2'b00) begin
                miscompares++;
                $display("FAIL midreset_quiet%0d: valid=%b busy=%b want 00 00", c, x_valid, busy);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 99) < 40);
            in_data  = 8'($urandom);
            bit_en   = ($urandom_range(0, 99) < 75);
            tick();
        end
        in_valid = 1'b0;
        bit_en = 1'b1;
        for (int c = 0; c < 30; c++) tick();
        vectors++;
        if (busy !== 2'b00 || in_ready !== 2'b11) begin
            miscompares++;
            $display("FAIL random_drain: busy=%b ready=%b want 00 11", busy, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_lsb_first();
        test_reset_mid_word();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
